// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions:
// FSM encoding, opcode field and PC increment.
package cpu_pkg;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT   = ST_BOOT,
    S_RUN    = ST_RUN,
    S_HALTED = ST_HALTED
  } fetch_state_e;

  localparam logic [5:0]  HALT_OPCODE_DEF = 6'b111111;
  localparam logic [31:0] PC_INC          = 32'd4;
  localparam int          OPC_HI          = 31;
  localparam int          OPC_LO          = 26;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory bus: fetch address out,
// combinational instruction word back.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (
    output imem_addr,
    input  imem_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable
// and a synchronous clear that wins over load.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc4,
  input  logic        d_valid,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc4,
  output logic        q_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // next contents: clear, load, or hold
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (clr) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d = d_instr;
      pc4_d   = d_pc4;
      valid_d = d_valid;
    end
  end

  // register update
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
    valid_q <= valid_d;
  end

  assign q_instr = instr_q;
  assign q_pc4   = pc4_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences
// BOOT/RUN/HALTED, feeds the IF/ID register.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int          CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  fetch_sequencer_if.master    bus,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 resume,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic                 halted,
  output logic                 misalign,
  output logic [CNT_W-1:0]     fetch_count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             ld;
  logic             flush;
  logic [31:0]      pc_inc;
  logic [31:0]      tgt;
  logic             is_halt;

  assign pc_inc  = pc_q + PC_INC;
  assign tgt     = {branch_target[31:2], 2'b00};
  assign is_halt =
    bus.imem_instr[OPC_HI:OPC_LO] == HALT_OPCODE;

  // next-state: branch beats stall/resume,
  // a halt word is latched then freezes fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    ld      = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (branch_taken) begin
          pc_d  = tgt;
          flush = 1'b1;
          mis_d = mis_q | (|branch_target[1:0]);
        end else if (!stall) begin
          ld   = 1'b1;
          pc_d = pc_inc;
          if (!(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
          if (is_halt)
            state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (branch_taken) begin
          pc_d    = tgt;
          flush   = 1'b1;
          mis_d   = mis_q | (|branch_target[1:0]);
          state_d = S_RUN;
        end else begin
          if (resume)
            state_d = S_RUN;
          if (!stall)
            flush = 1'b1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // FSM, PC, sticky flag and counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  if_id_reg u_if_id (
    .clk     (CLK),
    .clr     (RST | flush),
    .en      (ld),
    .d_instr (bus.imem_instr),
    .d_pc4   (pc_inc),
    .d_valid (1'b1),
    .q_instr (if_id_instr),
    .q_pc4   (if_id_pc4),
    .q_valid (if_id_valid)
  );

  assign bus.imem_addr = pc_q;
  assign halted        = state_q == S_HALTED;
  assign misalign      = mis_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer:
// directed scenarios then random traffic.
module tb_fetch_sequencer;

  logic        CLK = 1'b1;
  logic        RST = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        resume = 1'b0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign;
  logic [15:0] fetch_count;

  logic [31:0] halt_addr = 32'h8000_0000;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_sequencer_if bus ();

  always_comb
    bus.imem_instr = (bus.imem_addr == halt_addr) ?
      32'hFC00_0000 : bus.imem_addr + 32'd1;

  fetch_sequencer dut (
    .CLK           (CLK),
    .RST           (RST),
    .bus           (bus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .resume        (resume),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .misalign      (misalign),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        hlt;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
  mode_t       m_mode  = M_BOOT;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc4   = '0;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;
  int          m_cnt   = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFC00_0000 : a + 32'd1;
  endfunction

  task automatic redirect(input logic [31:0] t);
    m_pc    = t & 32'hFFFF_FFFC;
    m_valid = 1'b0;
    if (t[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  // behavioural reference: one clock edge
  task automatic model_edge();
    logic [31:0] w;
    if (RST) begin
      m_mode = M_BOOT; m_pc = 32'h0;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_mis = 0; m_cnt = 0;
      return;
    end
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN: begin
        if (branch_taken) redirect(branch_target);
        else if (!stall) begin
          w = mem_rd(m_pc);
          m_instr = w;
          m_pc4   = m_pc + 4;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
          if (m_cnt < 65535) m_cnt++;
          if (w[31:26] == 6'h3F) m_mode = M_HALT;
        end
      end
      default: begin
        if (branch_taken) begin
          redirect(branch_target);
          m_mode = M_RUN;
        end else begin
          if (resume) m_mode = M_RUN;
          if (!stall) m_valid = 1'b0;
        end
      end
    endcase
  endtask

  task automatic step(input logic rst, input logic stl,
                      input logic br, input logic [31:0] tgt,
                      input logic res);
    exp_t e;
    @(negedge CLK);
    RST = rst; stall = stl; branch_taken = br;
    branch_target = tgt; resume = res;
    model_edge();
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.hlt = (m_mode == M_HALT);
    e.mis = m_mis; e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // monitor: compare DUT outputs after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", bus.imem_addr, e.addr);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        if (e.valid) begin
          chk("if_id_instr", if_id_instr, e.instr);
          chk("if_id_pc4", if_id_pc4, e.pc4);
        end
        chk("halted", {31'b0, halted}, {31'b0, e.hlt});
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("fetch_count", {16'b0, fetch_count}, {16'b0, e.cnt});
      end
    end
  end

  initial begin
    logic [31:0] t;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(8);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(2);
    step(0, 1, 1, 32'h40, 0);
    idle(2);
    step(0, 0, 1, 32'h23, 0);
    idle(1);
    step(0, 0, 1, 32'h80, 0);
    idle(2);
    halt_addr = 32'h10;
    step(0, 0, 1, 32'h10, 0);
    idle(3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    halt_addr = 32'h8000_0000;
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    idle(3);
    halt_addr = 32'h10;
    step(0, 0, 1, 32'h10, 0);
    idle(2);
    step(1, 0, 1, 32'h44, 1);
    idle(3);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: t = $urandom;
        1: t = 32'hFFFF_FFFC | ($urandom & 32'h3);
        default: t = $urandom_range(0, 40);
      endcase
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           t,
           $urandom_range(0, 2) == 0);
    end
    idle(2);
    @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined CPU. It owns the PC, drives the instruction memory address, and captures fetched words into the IF/ID pipeline register. It applies stall, branch-redirect and halt sequencing. Sits between the instruction memory and the decode stage; hazard and branch resolution come from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OPCODE, 6'b111111, opcode field instr[31:26] that marks a halt instruction
CNT_W, 16, width of the saturating fetched-instruction counter

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
imem_addr  output  32  address to instruction memory; equals current PC
imem_instr  input  32  instruction word for imem_addr; combinational read, valid in the same cycle
stall  input  1  decode hazard: hold PC and IF/ID
branch_taken  input  1  resolved taken branch/jump this cycle
branch_target  input  32  redirect address, sampled when branch_taken=1
resume  input  1  leave HALTED state
if_id_instr  output  32  registered instruction to decode
if_id_pc4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  high while in HALTED
misalign  output  1  sticky: a branch_target with [1:0]!=0 was seen
fetch_count  output  CNT_W  number of instructions latched valid into IF/ID, saturating

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- On RST=1 at a rising edge:
  - PC<=RESET_PC; state<=BOOT
  - if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0
  - misalign<=0, fetch_count<=0
  - RST overrides every other input, including mid-branch and mid-halt.
- imem_addr = PC at all times, combinational from the PC register.
- States:
  - BOOT: one cycle after reset. if_id_valid stays 0, PC is unchanged, then go to RUN. Guarantees the first capture uses a settled address.
  - RUN: normal fetch.
  - HALTED: fetch frozen.
- RUN, per cycle, evaluated in priority order:
  1. branch_taken=1:
     - PC<={branch_target[31:2],2'b00}
     - if_id_valid<=0 (squash the wrong-path fetch)
     - misalign<=misalign|(branch_target[1:0]!=0)
     - Overrides stall.
  2. stall=1: PC, if_id_instr, if_id_pc4 and if_id_valid all hold.
  3. Otherwise:
     - if_id_instr<=imem_instr, if_id_pc4<=PC+4, if_id_valid<=1
     - PC<=PC+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0)
     - fetch_count increments and saturates at all-ones.
     - If imem_instr[31:26]==HALT_OPCODE, the halt word is still latched valid, PC<=PC+4, state<=HALTED.
- HALTED:
  - Cycle after entry: if_id_valid<=0; PC holds.
  - branch_taken=1: same redirect as RUN, state<=RUN (the halt was on a squashed path). Branch wins over resume.
  - resume=1 with no branch: state<=RUN; fetch restarts from the held PC on the following cycle.
  - stall in HALTED: holds IF/ID contents, including a valid halt word not yet consumed by decode.
- halted = (state==HALTED), registered.
- Latency:
  - Instruction at address A is visible on if_id_instr one edge after imem_addr==A with no stall.
  - Branch penalty is one bubble: target fetch is visible two edges after branch_taken.

Decomposition:
- Shared package cpu_pkg:
  - state encoding localparams ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALTED=2'd2
  - HALT_OPCODE default
  - PC_INC=32'd4
  - opcode field slice constants [31:26]
- Sub-module if_id_reg: IF/ID pipeline register with enable (~stall) and synchronous clear (squash/reset) for instr, pc4, valid. Natural split; the decode stage also needs it.
- Counter and FSM stay in fetch_sequencer.

Test Plan:
- Reset and sequential fetch: RST for 2 cycles, then run 8 cycles, memory word at addr = addr+1 → imem_addr steps 0,0(BOOT),4,8,12…; if_id_instr 1,5,9 with if_id_pc4 4,8,12; if_id_valid=0 during BOOT; fetch_count=7 after 8 cycles.
- Stall hold: assert stall for 3 cycles at PC=12 → imem_addr stays 12; if_id_instr/pc4/valid unchanged; fetch_count unchanged; fetch resumes at 12 after release.
- Branch over stall: stall=1 and branch_taken=1, target=32'h40 in the same cycle → next cycle imem_addr=0x40 and if_id_valid=0; the following cycle if_id_pc4=0x44 and valid=1.
- Misaligned target: branch_target=32'h23 → imem_addr=0x20, misalign=1 and remains 1 through later aligned branches until RST.
- Halt and resume: word 0xFC000000 at 0x10 → captured valid with if_id_pc4=0x14, halted=1, imem_addr frozen at 0x14, valid=0 next cycle; resume=1 → fetch of 0x14 latched valid one cycle later.
- Wrap and reset mid-halt: branch to 0xFFFFFFFC, run 2 cycles → imem_addr becomes 0; in HALTED assert RST → halted=0, imem_addr=RESET_PC, valid=0, fetch_count=0.
